spi_baud_gen: RTL and testbench

Baud-rate and SCLK generator for the APB SPI master. It sits directly upstream of the shift-register stage. It divides PCLK down to the serial clock `sclk_o` and produces the single-cycle launch and capture strobes that the shift register uses to drive MOSI and sample MISO. Divisor, polarity and mode come from the APB register block. `ss_i` comes from the slave-select controller.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_baud_gen.sv | 88 ++++++++
 tb/tb_spi_baud_gen.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: mode encodings, divisor width and
// the baud divisor function used by the baud/SCLK generator.
package spi_pkg;

   localparam int DIV_W = 12;

   typedef enum logic [1:0] {
      SPI_RUN  = 2'b00,
      SPI_WAIT = 2'b01,
      SPI_STOP = 2'b10
   } spi_mode_e;

   // Divisor = (sppr+1) << (spr+1); the shift amount is widened so spr=7 gives 8.
   function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sppr,
                                                 input logic [2:0] spr);
      logic [DIV_W-1:0] base;
      base = DIV_W'(sppr) + DIV_W'(1);
      return base << ({1'b0, spr} + 4'd1);
   endfunction

endpackage

// File: rtl/spi_baud_gen.sv
// Baud-rate and SCLK generator: divides PCLK to SCLK and decodes the
// one-cycle launch/capture strobes for the shift-register stage.
module spi_baud_gen #(
   parameter int DIV_W = 12
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic [1:0]       spi_mode_i,
   input  logic             spiswai_i,
   input  logic [2:0]       sppr_i,
   input  logic [2:0]       spr_i,
   input  logic             cpol_i,
   input  logic             cpha_i,
   input  logic             ss_i,
   output logic             sclk_o,
   output logic             mosi_send_sclk_o,
   output logic             mosi_send_sclk0_o,
   output logic             miso_receive_sclk_o,
   output logic             miso_receive_sclk0_o,
   output logic [DIV_W-1:0] baud_rate_div_o
);
   import spi_pkg::*;

   logic [DIV_W-1:0] r_count;
   logic             r_sclk;
   logic [DIV_W-1:0] w_div;
   logic [DIV_W-1:0] w_half;
   logic [DIV_W-1:0] w_half_m1;
   logic [DIV_W-1:0] w_launch_cnt;
   logic             w_active;
   logic             w_wrap;
   logic             w_capture;
   logic             w_launch;
   logic             w_unused_cpha;

   // Edge selection by CPHA happens in the shift register; all four strobes are driven here.
   assign w_unused_cpha = cpha_i;

   // Divisor is purely combinational so it tracks the register block even in reset.
   assign w_div           = DIV_W'(baud_div(sppr_i, spr_i));
   assign baud_rate_div_o = w_div;
   assign w_half          = w_div >> 1;
   assign w_half_m1       = w_half - DIV_W'(1);
   // With half==1 there is no earlier cycle to launch in, so launch shares the capture cycle.
   assign w_launch_cnt    = (w_half == DIV_W'(1)) ? '0 : (w_half - DIV_W'(2));

   assign w_active = !ss_i &&
                     ((spi_mode_i == SPI_RUN) ||
                      ((spi_mode_i == SPI_WAIT) && !spiswai_i));

   // ">=" rather than "==" so a divisor shrunk mid-transfer wraps on the next edge.
   assign w_wrap = (r_count >= w_half_m1);

   // Half-period counter: runs while active, held at zero otherwise.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         r_count <= '0;
      else if (!w_active)
         r_count <= '0;
      else if (w_wrap)
         r_count <= '0;
      else
         r_count <= r_count + DIV_W'(1);
   end

   // SCLK register: parks at CPOL when idle, toggles on each counter wrap.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         r_sclk <= 1'b0;
      else if (!w_active)
         r_sclk <= cpol_i;
      else if (w_wrap)
         r_sclk <= ~r_sclk;
   end

   assign sclk_o = r_sclk;

   // Strobe decode: the current SCLK level picks which edge the next toggle will be.
   always_comb begin
      w_capture            = w_active && (r_count == w_half_m1);
      w_launch             = w_active && (r_count == w_launch_cnt);
      miso_receive_sclk_o  = w_capture && !r_sclk;
      miso_receive_sclk0_o = w_capture &&  r_sclk;
      mosi_send_sclk_o     = w_launch  && !r_sclk;
      mosi_send_sclk0_o    = w_launch  &&  r_sclk;
   end

endmodule

// File: tb/tb_spi_baud_gen.sv
// Self-checking bench for spi_baud_gen: directed scenarios plus randomized
// segments compared against an elapsed-time model of the SCLK waveform.
module tb_spi_baud_gen;

   logic        PCLK;
   logic        PRESETn;
   logic [1:0]  spi_mode_i;
   logic        spiswai_i;
   logic [2:0]  sppr_i;
   logic [2:0]  spr_i;
   logic        cpol_i;
   logic        cpha_i;
   logic        ss_i;
   logic        sclk_o;
   logic        mosi_send_sclk_o;
   logic        mosi_send_sclk0_o;
   logic        miso_receive_sclk_o;
   logic        miso_receive_sclk0_o;
   logic [11:0] baud_rate_div_o;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: t = PCLK edges since activation, lvl = SCLK level at activation.
   int m_t    = 0;
   bit m_lvl  = 0;
   bit m_sclk = 0;

   spi_baud_gen #(.DIV_W(12)) dut (
      .PCLK                 (PCLK),
      .PRESETn              (PRESETn),
      .spi_mode_i           (spi_mode_i),
      .spiswai_i            (spiswai_i),
      .sppr_i               (sppr_i),
      .spr_i                (spr_i),
      .cpol_i               (cpol_i),
      .cpha_i               (cpha_i),
      .ss_i                 (ss_i),
      .sclk_o               (sclk_o),
      .mosi_send_sclk_o     (mosi_send_sclk_o),
      .mosi_send_sclk0_o    (mosi_send_sclk0_o),
      .miso_receive_sclk_o  (miso_receive_sclk_o),
      .miso_receive_sclk0_o (miso_receive_sclk0_o),
      .baud_rate_div_o      (baud_rate_div_o)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_div();
      return (int'(sppr_i) + 1) * (2 ** (int'(spr_i) + 1));
   endfunction

   function automatic bit model_active();
      return !ss_i && (spi_mode_i == 2'b00 || (spi_mode_i == 2'b01 && !spiswai_i));
   endfunction

   task automatic check_all();
      int h;
      int p;
      bit act;
      bit cap;
      bit lau;
      h   = exp_div() / 2;
      act = model_active();
      p   = m_t % h;
      cap = act && (p == h - 1);
      lau = act && (p == ((h == 1) ? 0 : h - 2));
      chk("div",      int'(baud_rate_div_o),      exp_div());
      chk("sclk",     int'(sclk_o),               int'(m_sclk));
      chk("cap_rise", int'(miso_receive_sclk_o),  int'(cap && !m_sclk));
      chk("cap_fall", int'(miso_receive_sclk0_o), int'(cap &&  m_sclk));
      chk("lau_rise", int'(mosi_send_sclk_o),     int'(lau && !m_sclk));
      chk("lau_fall", int'(mosi_send_sclk0_o),    int'(lau &&  m_sclk));
   endtask

   // One PCLK: advance the model on the rising edge, check on the falling edge.
   task automatic tick();
      @(posedge PCLK);
      if (PRESETn) begin
         if (model_active()) begin
            m_t++;
            m_sclk = m_lvl ^ (((m_t / (exp_div() / 2)) % 2) == 1);
         end else begin
            m_t    = 0;
            m_lvl  = cpol_i;
            m_sclk = cpol_i;
         end
      end
      @(negedge PCLK);
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int n;
      int last_rise;
      bit prev;

      PRESETn = 1'b0; spi_mode_i = 2'b00; spiswai_i = 1'b0;
      sppr_i = 3'd0; spr_i = 3'd0; cpol_i = 1'b0; cpha_i = 1'b0; ss_i = 1'b1;

      // Reset state, divisor visible during reset.
      #23;
      chk("rst_sclk", int'(sclk_o), 0);
      chk("rst_strb", int'({mosi_send_sclk_o, mosi_send_sclk0_o,
                            miso_receive_sclk_o, miso_receive_sclk0_o}), 0);
      chk("rst_div",  int'(baud_rate_div_o), 2);
      @(negedge PCLK);
      PRESETn = 1'b1;
      run(2);

      // Fastest divisor: SCLK toggles every PCLK, launch == capture.
      ss_i = 1'b0;
      run(10);
      ss_i = 1'b1;
      run(2);

      // Divisor 12: first rise after 6 edges.
      sppr_i = 3'd2; spr_i = 3'd1; cpol_i = 1'b0;
      run(1);
      ss_i = 1'b0;
      n = 0;
      while (!sclk_o && n < 20) begin
         tick();
         n++;
      end
      chk("first_rise", n, 6);
      run(40);

      // cpol=1, then deselect mid-period; a cpol change while active is ignored.
      ss_i = 1'b1; cpol_i = 1'b1;
      run(2);
      ss_i = 1'b0;
      run(8);
      cpol_i = 1'b0;
      run(3);
      cpol_i = 1'b1;
      run(2);
      ss_i = 1'b1;
      run(3);

      // WAIT mode with spiswai freeze and restart.
      spi_mode_i = 2'b01; ss_i = 1'b0;
      run(20);
      spiswai_i = 1'b1;
      run(5);
      spiswai_i = 1'b0;
      run(15);
      spi_mode_i = 2'b11;
      run(4);
      spi_mode_i = 2'b00;
      run(10);

      // Async reset mid-transfer with SCLK high.
      ss_i = 1'b1; cpol_i = 1'b0;
      run(2);
      ss_i = 1'b0;
      run(8);
      chk("pre_rst_sclk", int'(sclk_o), 1);
      #2 PRESETn = 1'b0;
      #1;
      chk("async_sclk", int'(sclk_o), 0);
      chk("async_strb", int'({mosi_send_sclk_o, mosi_send_sclk0_o,
                              miso_receive_sclk_o, miso_receive_sclk0_o}), 0);
      m_t = 0; m_lvl = 1'b0; m_sclk = 1'b0;
      run(2);
      PRESETn = 1'b1;
      run(10);

      // Largest divisor: period exactly 2048 PCLK.
      ss_i = 1'b1; sppr_i = 3'd7; spr_i = 3'd7;
      run(1);
      chk("div_max", int'(baud_rate_div_o), 2048);
      ss_i = 1'b0;
      last_rise = -1;
      prev = sclk_o;
      for (int i = 0; i < 5200; i++) begin
         tick();
         if (sclk_o && !prev) begin
            if (last_rise >= 0) chk("period2048", i - last_rise, 2048);
            last_rise = i;
         end
         prev = sclk_o;
      end
      chk("saw_rise", int'(last_rise >= 0), 1);

      // Randomized segments; divisor only changes on an idle cycle.
      for (int seg = 0; seg < 30; seg++) begin
         ss_i   = 1'b1;
         sppr_i = 3'($urandom_range(0, 7));
         spr_i  = 3'($urandom_range(0, 3));
         cpol_i = 1'($urandom_range(0, 1));
         cpha_i = 1'($urandom_range(0, 1));
         run(1);
         ss_i = 1'b0;
         n = $urandom_range(20, 90);
         for (int c = 0; c < n; c++) begin
            if ($urandom_range(0, 15) == 0) ss_i       = ~ss_i;
            if ($urandom_range(0, 15) == 0) spi_mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) spiswai_i  = ~spiswai_i;
            if ($urandom_range(0, 7)  == 0) cpol_i     = ~cpol_i;
            tick();
         end
         spi_mode_i = 2'b00;
         spiswai_i  = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
